mem_access_unit: RTL and testbench

Parametrised memory-access pipeline stage between execute and writeback. Accepts one instruction per handshake and drives the data bus with a held-until-accepted request. Extracts and sign/zero-extends load data, and registers the result toward writeback. Compared with the previous memory stage it adds:
- configurable data width;
- misalignment exceptions;
- flush with response draining;
- a result hold register so a writeback stall never loses a `data_ok` beat.

---
 rtl/pipeline_pkg.sv | 84 ++++++++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: memory op codes, bus transfer sizes and memory-stage FSM states.
// Latency: none. It only holds types and pure helper functions.
// Backpressure: not applicable.
package pipeline_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LBU  = 4'd2,
        MOP_LH   = 4'd3,
        MOP_LHU  = 4'd4,
        MOP_LW   = 4'd5,
        MOP_LWU  = 4'd6,
        MOP_LD   = 4'd7,
        MOP_SB   = 4'd8,
        MOP_SH   = 4'd9,
        MOP_SW   = 4'd10,
        MOP_SD   = 4'd11
    } mem_op_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } mau_state_t;

    function automatic logic op_is_load(input mem_op_t op);
        return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) || (op == MOP_LHU) ||
               (op == MOP_LW) || (op == MOP_LWU) || (op == MOP_LD);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW) || (op == MOP_SD);
    endfunction

    // Ops that only exist on a 64-bit data path.
    function automatic logic op_needs_dw64(input mem_op_t op);
        return (op == MOP_LWU) || (op == MOP_LD) || (op == MOP_SD);
    endfunction

    function automatic logic [3:0] op_bytes(input mem_op_t op);
        logic [3:0] n;
        case (op)
            MOP_LB, MOP_LBU, MOP_SB:         n = 4'd1;
            MOP_LH, MOP_LHU, MOP_SH:         n = 4'd2;
            MOP_LW, MOP_LWU, MOP_SW:         n = 4'd4;
            MOP_LD, MOP_SD:                  n = 4'd8;
            default:                         n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic msize_t op_size(input mem_op_t op);
        msize_t s;
        case (op_bytes(op))
            4'd2:    s = MSIZE2;
            4'd4:    s = MSIZE4;
            4'd8:    s = MSIZE8;
            default: s = MSIZE1;
        endcase
        return s;
    endfunction

    // Natural alignment check on the low three address bits.
    function automatic logic op_misaligned(input mem_op_t op, input logic [2:0] a);
        logic m;
        case (op_bytes(op))
            4'd2:    m = a[0];
            4'd4:    m = |a[1:0];
            4'd8:    m = |a[2:0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store strobe/data placement and load extraction with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import pipeline_pkg::*;
#(
    parameter int DW = 32
) (
    input  mem_op_t                   op,
    input  logic [$clog2(DW/8)-1:0]   off,
    input  logic [DW-1:0]             wdata,
    input  logic [DW-1:0]             rdata,
    output logic [DW/8-1:0]           strobe,
    output logic [DW-1:0]             sdata,
    output logic [DW-1:0]             ldata,
    output msize_t                    size
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    logic [OW+2:0]  bit_sh;
    logic [BW-1:0]  base;
    logic [DW-1:0]  rsh;
    logic [63:0]    r64;
    logic [63:0]    ext;

    assign bit_sh = {off, 3'b000};

    // Store side: contiguous byte mask for the access size, moved up to the addressed lane.
    always_comb begin
        base = '0;
        case (op_bytes(op))
            4'd1:    base[0]   = 1'b1;
            4'd2:    base[1:0] = 2'b11;
            4'd4:    base[3:0] = 4'hF;
            4'd8:    base      = '1;
            default: base      = '0;
        endcase
        strobe = base << off;
        sdata  = wdata << bit_sh;
        size   = op_size(op);
    end

    // Load side: bring the addressed lane to bit 0, then extend from the access width.
    // Working in 64 bits keeps one extension table valid for both data-path widths.
    always_comb begin
        rsh = rdata >> bit_sh;
        r64 = 64'(rsh);
        case (op)
            MOP_LB:  ext = {{56{r64[7]}},  r64[7:0]};
            MOP_LBU: ext = {56'd0,         r64[7:0]};
            MOP_LH:  ext = {{48{r64[15]}}, r64[15:0]};
            MOP_LHU: ext = {48'd0,         r64[15:0]};
            MOP_LW:  ext = {{32{r64[31]}}, r64[31:0]};
            MOP_LWU: ext = {32'd0,         r64[31:0]};
            MOP_LD:  ext = r64;
            default: ext = 64'd0;
        endcase
        ldata = ext[DW-1:0];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: issues one held data-bus request per op, aligns load data, holds the result for writeback.
// Latency: 1 cycle for ALU pass-through / misaligned ops; memory ops 2 cycles minimum (accept -> req -> result).
// Backpressure: in_ready drops while a bus op is in flight, while a result waits on out_ready, and during flush.
module mem_access_unit
    import pipeline_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  mem_op_t           in_op,
    input  logic [AW-1:0]     in_addr,
    input  logic [DW-1:0]     in_wdata,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_regw,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_regw,
    output logic              out_wen,
    output logic [DW-1:0]     out_data,
    output logic              out_adel,
    output logic              out_ades,
    output logic              dreq_valid,
    output logic [AW-1:0]     dreq_addr,
    output msize_t            dreq_size,
    output logic [DW/8-1:0]   dreq_strobe,
    output logic [DW-1:0]     dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DW-1:0]     dresp_data
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    mau_state_t     state;
    logic           alive;
    logic           killed;
    mem_op_t        op_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [31:0]    pc_q;
    logic [4:0]     regw_q;

    logic           accept;
    logic           in_supported;
    logic           in_misal;
    logic           in_mem;
    logic           resp_done;
    logic           is_req;

    logic [BW-1:0]  la_strobe;
    logic [DW-1:0]  la_sdata;
    logic [DW-1:0]  la_ldata;
    msize_t         la_size;

    // alive keeps in_ready low during reset and for the first cycle after release.
    assign in_ready  = alive && !flush && !killed &&
                       ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;

    // Ops outside the configured width complete immediately as no-ops with no register write.
    assign in_supported = (DW == 64) || !op_needs_dw64(in_op);
    assign in_misal     = in_supported && op_misaligned(in_op, in_addr[2:0]);
    assign in_mem       = (in_op != MOP_NONE) && in_supported && !in_misal;

    // data_ok can only legally arrive with or after addr_ok, so it closes the transaction in REQ or WAIT.
    assign resp_done = ((state == REQ) && dresp_addr_ok && dresp_data_ok) ||
                       ((state == WAIT) && dresp_data_ok);

    assign is_req     = (state == REQ);
    assign out_valid  = (state == HOLD);
    assign dreq_valid = is_req;

    // Request fields come from latched state so they stay put until addr_ok.
    assign dreq_addr   = is_req ? addr_q    : '0;
    assign dreq_strobe = is_req ? la_strobe : '0;
    assign dreq_data   = is_req ? la_sdata  : '0;
    assign dreq_size   = is_req ? la_size   : MSIZE1;

    mem_lane_align #(
        .DW (DW)
    ) u_align (
        .op     (op_q),
        .off    (addr_q[OW-1:0]),
        .wdata  (wdata_q),
        .rdata  (dresp_data),
        .strobe (la_strobe),
        .sdata  (la_sdata),
        .ldata  (la_ldata),
        .size   (la_size)
    );

    // Stage FSM plus the result register; a killed op drains its response and never reaches HOLD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            alive    <= 1'b0;
            killed   <= 1'b0;
            op_q     <= MOP_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            regw_q   <= '0;
            out_pc   <= '0;
            out_regw <= '0;
            out_wen  <= 1'b0;
            out_data <= '0;
            out_adel <= 1'b0;
            out_ades <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (accept) begin
                if (!in_mem) begin
                    state    <= HOLD;
                    out_pc   <= in_pc;
                    out_regw <= in_regw;
                    out_data <= (in_op == MOP_NONE) ? in_wdata : '0;
                    out_wen  <= (in_op == MOP_NONE) && (in_regw != 5'd0);
                    out_adel <= in_misal && op_is_load(in_op);
                    out_ades <= in_misal && op_is_store(in_op);
                end else begin
                    state   <= REQ;
                    killed  <= 1'b0;
                    op_q    <= in_op;
                    addr_q  <= in_addr;
                    wdata_q <= in_wdata;
                    pc_q    <= in_pc;
                    regw_q  <= in_regw;
                end
            end else begin
                case (state)
                    IDLE: ;
                    HOLD: begin
                        if (flush || out_ready) begin
                            state <= IDLE;
                        end
                    end
                    REQ, WAIT: begin
                        if (flush) begin
                            killed <= 1'b1;
                        end
                        if (resp_done) begin
                            killed <= 1'b0;
                            if (killed || flush) begin
                                state <= IDLE;
                            end else begin
                                state    <= HOLD;
                                out_pc   <= pc_q;
                                out_regw <= regw_q;
                                out_data <= op_is_load(op_q) ? la_ldata : '0;
                                out_wen  <= op_is_load(op_q);
                                out_adel <= 1'b0;
                                out_ades <= 1'b0;
                            end
                        end else if ((state == REQ) && dresp_addr_ok) begin
                            state <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The bus must never return data ahead of accepting the address.
    property p_no_early_data;
        @(posedge clk) disable iff (!resetn)
            dresp_data_ok |-> ((state == WAIT) || ((state == REQ) && dresp_addr_ok));
    endproperty
    a_no_early_data: assert property (p_no_early_data);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, in_valid, flush, out_ready, addr_ok, data_ok, skip32, w64;
    mem_op_t     in_op;
    logic [31:0] in_addr, in_pc;
    logic [63:0] in_wdata, dresp_data;
    logic [4:0]  in_regw;

    // DW=32 instance
    logic        a_in_ready, a_out_valid, a_out_wen, a_out_adel, a_out_ades, a_dreq_valid;
    logic [31:0] a_out_pc, a_out_data, a_dreq_addr, a_dreq_data;
    logic [4:0]  a_out_regw;
    msize_t      a_dreq_size;
    logic [3:0]  a_dreq_strobe;
    // DW=64 instance
    logic        b_in_ready, b_out_valid, b_out_wen, b_out_adel, b_out_ades, b_dreq_valid;
    logic [31:0] b_out_pc, b_dreq_addr;
    logic [63:0] b_out_data, b_dreq_data;
    logic [4:0]  b_out_regw;
    msize_t      b_dreq_size;
    logic [7:0]  b_dreq_strobe;

    mem_access_unit #(.DW(32), .AW(32)) u32 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .in_pc(in_pc),
        .in_regw(in_regw), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_regw(a_out_regw), .out_wen(a_out_wen), .out_data(a_out_data),
        .out_adel(a_out_adel), .out_ades(a_out_ades), .dreq_valid(a_dreq_valid),
        .dreq_addr(a_dreq_addr), .dreq_size(a_dreq_size), .dreq_strobe(a_dreq_strobe),
        .dreq_data(a_dreq_data), .dresp_addr_ok(addr_ok & ~skip32),
        .dresp_data_ok(data_ok & ~skip32), .dresp_data(dresp_data[31:0])
    );

    mem_access_unit #(.DW(64), .AW(32)) u64 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_pc(in_pc),
        .in_regw(in_regw), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_regw(b_out_regw), .out_wen(b_out_wen), .out_data(b_out_data),
        .out_adel(b_out_adel), .out_ades(b_out_ades), .dreq_valid(b_dreq_valid),
        .dreq_addr(b_dreq_addr), .dreq_size(b_dreq_size), .dreq_strobe(b_dreq_strobe),
        .dreq_data(b_dreq_data), .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok),
        .dresp_data(dresp_data)
    );

    // View of whichever instance the current check targets.
    logic        s_in_ready, s_out_valid, s_out_wen, s_adel, s_ades, s_dreq_valid;
    logic [31:0] s_out_pc, s_dreq_addr;
    logic [63:0] s_out_data, s_dreq_data;
    logic [4:0]  s_out_regw;
    logic [2:0]  s_size;
    logic [7:0]  s_strobe;
    assign s_in_ready   = w64 ? b_in_ready    : a_in_ready;
    assign s_out_valid  = w64 ? b_out_valid   : a_out_valid;
    assign s_out_wen    = w64 ? b_out_wen     : a_out_wen;
    assign s_adel       = w64 ? b_out_adel    : a_out_adel;
    assign s_ades       = w64 ? b_out_ades    : a_out_ades;
    assign s_dreq_valid = w64 ? b_dreq_valid  : a_dreq_valid;
    assign s_out_pc     = w64 ? b_out_pc      : a_out_pc;
    assign s_dreq_addr  = w64 ? b_dreq_addr   : a_dreq_addr;
    assign s_out_data   = w64 ? b_out_data    : {32'd0, a_out_data};
    assign s_dreq_data  = w64 ? b_dreq_data   : {32'd0, a_dreq_data};
    assign s_out_regw   = w64 ? b_out_regw    : a_out_regw;
    assign s_size       = w64 ? b_dreq_size   : a_dreq_size;
    assign s_strobe     = w64 ? b_dreq_strobe : {4'd0, a_dreq_strobe};

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (w64=%0d): got %h, expected %h", name, w64, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [4:0]  regw;
        logic [63:0] rdata;
        logic        w64;
        logic        mem;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] dq;
        logic        cd;
        logic [63:0] data;
        logic        wen;
        logic        adel;
        logic        ades;
    } vec_t;

    vec_t tbl[16];

    initial begin
        //            op        addr        wdata                   regw  rdata                   w64   mem   size  strobe dreq_data               cd    data                    wen   adel  ades
        tbl[0]  = '{MOP_NONE, 32'h100, 64'h1234,               5'd5, 64'h0,                  1'b0, 1'b0, 3'd0, 8'h00, 64'h0,                  1'b1, 64'h1234,               1'b1, 1'b0, 1'b0};
        tbl[1]  = '{MOP_NONE, 32'h100, 64'h1234,               5'd0, 64'h0,                  1'b0, 1'b0, 3'd0, 8'h00, 64'h0,                  1'b1, 64'h1234,               1'b0, 1'b0, 1'b0};
        tbl[2]  = '{MOP_LB,   32'h103, 64'h0,                  5'd5, 64'h80FF_0000,          1'b0, 1'b1, 3'd0, 8'h08, 64'h0,                  1'b1, 64'hFFFF_FF80,          1'b1, 1'b0, 1'b0};
        tbl[3]  = '{MOP_LBU,  32'h103, 64'h0,                  5'd5, 64'h80FF_0000,          1'b0, 1'b1, 3'd0, 8'h08, 64'h0,                  1'b1, 64'h0000_0080,          1'b1, 1'b0, 1'b0};
        tbl[4]  = '{MOP_LH,   32'h102, 64'h0,                  5'd5, 64'h8001_0000,          1'b0, 1'b1, 3'd1, 8'h0C, 64'h0,                  1'b1, 64'hFFFF_8001,          1'b1, 1'b0, 1'b0};
        tbl[5]  = '{MOP_LW,   32'h100, 64'h0,                  5'd5, 64'hDEAD_BEEF,          1'b0, 1'b1, 3'd2, 8'h0F, 64'h0,                  1'b1, 64'hDEAD_BEEF,          1'b1, 1'b0, 1'b0};
        tbl[6]  = '{MOP_SH,   32'h206, 64'hBEEF,               5'd0, 64'h0,                  1'b1, 1'b1, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0, 64'h0,                  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{MOP_LWU,  32'h104, 64'h0,                  5'd5, 64'h8000_0001_0000_0000, 1'b1, 1'b1, 3'd2, 8'hF0, 64'h0,                 1'b1, 64'h0000_0000_8000_0001, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{MOP_LW,   32'h104, 64'h0,                  5'd5, 64'h8000_0001_0000_0000, 1'b1, 1'b1, 3'd2, 8'hF0, 64'h0,                 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{MOP_LD,   32'h108, 64'h0,                  5'd5, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 3'd3, 8'hFF, 64'h0,                 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{MOP_SB,   32'h105, 64'hAA,                 5'd0, 64'h0,                  1'b1, 1'b1, 3'd0, 8'h20, 64'h0000_AA00_0000_0000, 1'b0, 64'h0,                  1'b0, 1'b0, 1'b0};
        tbl[11] = '{MOP_LW,   32'h102, 64'h0,                  5'd3, 64'h0,                  1'b0, 1'b0, 3'd0, 8'h00, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b1, 1'b0};
        tbl[12] = '{MOP_SW,   32'h101, 64'h5,                  5'd3, 64'h0,                  1'b0, 1'b0, 3'd0, 8'h00, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b0, 1'b1};
        tbl[13] = '{MOP_LD,   32'h10C, 64'h0,                  5'd3, 64'h0,                  1'b1, 1'b0, 3'd0, 8'h00, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b1, 1'b0};
        tbl[14] = '{MOP_SD,   32'h100, 64'h1122_3344_5566_7788, 5'd0, 64'h0,                 1'b1, 1'b1, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0,                 1'b0, 1'b0, 1'b0};
        tbl[15] = '{MOP_SH,   32'h101, 64'h7,                  5'd0, 64'h0,                  1'b0, 1'b0, 3'd0, 8'h00, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b0, 1'b1};

        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        addr_ok = 1'b0; data_ok = 1'b0; skip32 = 1'b0; w64 = 1'b0;
        in_op = MOP_NONE; in_addr = '0; in_wdata = '0; in_pc = '0; in_regw = '0; dresp_data = '0;

        // Reset state on both widths
        step(); step();
        for (int k = 0; k < 2; k++) begin
            w64 = k[0];
            #1;
            chk("rst_out_valid", s_out_valid, 0);
            chk("rst_dreq_valid", s_dreq_valid, 0);
            chk("rst_in_ready", s_in_ready, 0);
            chk("rst_out_data", s_out_data, 0);
            chk("rst_strobe", s_strobe, 0);
        end
        resetn = 1'b1;
        step(); step();

        // Table of single transactions; memory ops get addr_ok+data_ok in the first request cycle
        for (int i = 0; i < 16; i++) begin
            w64 = tbl[i].w64;
            skip32 = (tbl[i].op == MOP_LWU) || (tbl[i].op == MOP_LD) || (tbl[i].op == MOP_SD);
            in_op = tbl[i].op; in_addr = tbl[i].addr; in_wdata = tbl[i].wdata;
            in_regw = tbl[i].regw; in_pc = 32'h1000 + 32'(i * 4); in_valid = 1'b1;
            #1 chk("in_ready", s_in_ready, 1);
            step();
            in_valid = 1'b0; in_op = MOP_NONE;
            if (tbl[i].mem) begin
                chk("dreq_valid", s_dreq_valid, 1);
                chk("dreq_size", s_size, tbl[i].size);
                chk("dreq_strobe", s_strobe, tbl[i].strobe);
                chk("dreq_data", s_dreq_data, tbl[i].dq);
                addr_ok = 1'b1; data_ok = 1'b1; dresp_data = tbl[i].rdata;
                step();
                addr_ok = 1'b0; data_ok = 1'b0;
            end else begin
                chk("no_dreq", s_dreq_valid, 0);
            end
            chk("out_valid", s_out_valid, 1);
            chk("out_pc", s_out_pc, 32'h1000 + 32'(i * 4));
            chk("out_wen", s_out_wen, tbl[i].wen);
            chk("out_adel", s_adel, tbl[i].adel);
            chk("out_ades", s_ades, tbl[i].ades);
            if (tbl[i].cd) chk("out_data", s_out_data, tbl[i].data);
            step();
        end
        skip32 = 1'b0;

        // SH on DW=64 held three cycles with the request fields unchanged
        w64 = 1'b1;
        in_op = MOP_SH; in_addr = 32'h206; in_wdata = 64'hBEEF; in_regw = 5'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_op = MOP_NONE; in_addr = 32'hFFF0; in_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int c = 0; c < 3; c++) begin
            chk("hold_dreq_valid", s_dreq_valid, 1);
            chk("hold_dreq_addr", s_dreq_addr, 32'h206);
            chk("hold_dreq_strobe", s_strobe, 8'hC0);
            chk("hold_dreq_data", s_dreq_data, 64'hBEEF_0000_0000_0000);
            if (c == 2) begin addr_ok = 1'b1; data_ok = 1'b1; end
            step();
        end
        addr_ok = 1'b0; data_ok = 1'b0;
        chk("sh_out_valid", s_out_valid, 1);
        chk("sh_out_wen", s_out_wen, 0);
        step();

        // Flush during REQ: drain, never produce a result
        w64 = 1'b0;
        in_op = MOP_LW; in_addr = 32'h100; in_wdata = 64'h0; in_regw = 5'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_op = MOP_NONE;
        flush = 1'b1;
        #1 chk("fl_in_ready", s_in_ready, 0);
        chk("fl_dreq_valid", s_dreq_valid, 1);
        step();
        flush = 1'b0;
        chk("fl_req_kept", s_dreq_valid, 1);
        chk("fl_noval1", s_out_valid, 0);
        chk("fl_in_ready1", s_in_ready, 0);
        step();
        addr_ok = 1'b1;
        chk("fl_req_kept2", s_dreq_valid, 1);
        step();
        addr_ok = 1'b0; data_ok = 1'b1; dresp_data = 64'h1234_5678;
        chk("fl_in_ready2", s_in_ready, 0);
        chk("fl_noval2", s_out_valid, 0);
        chk("fl_dreq_off", s_dreq_valid, 0);
        step();
        data_ok = 1'b0;
        chk("fl_in_ready_back", s_in_ready, 1);
        chk("fl_noval3", s_out_valid, 0);
        step();
        chk("fl_noval4", s_out_valid, 0);

        // Writeback stall: result held four cycles, then same-cycle accept of the next op
        out_ready = 1'b0;
        in_op = MOP_LW; in_addr = 32'h100; in_regw = 5'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_op = MOP_NONE;
        addr_ok = 1'b1; data_ok = 1'b1; dresp_data = 64'hCAFE_F00D;
        step();
        addr_ok = 1'b0; data_ok = 1'b0; dresp_data = '1;
        for (int c = 0; c < 4; c++) begin
            chk("stall_valid", s_out_valid, 1);
            chk("stall_data", s_out_data, 64'hCAFE_F00D);
            chk("stall_in_ready", s_in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        in_op = MOP_NONE; in_wdata = 64'h55; in_regw = 5'd7; in_valid = 1'b1;
        #1 chk("release_in_ready", s_in_ready, 1);
        step();
        // Back-to-back pass-through: a second op accepted straight out of HOLD
        in_wdata = 64'h66; in_regw = 5'd8;
        chk("next_data", s_out_data, 64'h55);
        chk("next_regw", s_out_regw, 7);
        chk("b2b_in_ready", s_in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", s_out_valid, 1);
        chk("b2b_data", s_out_data, 64'h66);
        step();
        chk("b2b_idle", s_out_valid, 0);

        // Reset in the middle of a request drops it immediately
        in_op = MOP_LW; in_addr = 32'h100; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_op = MOP_NONE;
        chk("mid_req", s_dreq_valid, 1);
        resetn = 1'b0;
        #1 chk("mid_rst_dreq", s_dreq_valid, 0);
        chk("mid_rst_ready", s_in_ready, 0);
        step();
        resetn = 1'b1;
        step(); step();
        chk("post_rst_ready", s_in_ready, 1);
        chk("post_rst_valid", s_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
